// File: rtl/uart_tx_fifo_module_if.sv
// Host/transmitter-side signal bundle for uart_tx_fifo_module.
// master: host logic and transmit control stage (drive writes and TX_Done_Sig, observe status).
// slave : the FIFO/sequencer itself (drives TX_En_Sig/TX_Data and status flags).
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              Wr_En_Sig;
  logic [7:0]        Wr_Data;
  logic              TX_Done_Sig;
  logic              TX_En_Sig;
  logic [7:0]        TX_Data;
  logic              Full_Sig;
  logic              Empty_Sig;
  logic [ADDR_W:0]   Count;
  logic              Overflow_Sig;
  logic              Busy_Sig;

  modport master (
    output Wr_En_Sig, Wr_Data, TX_Done_Sig,
    input  TX_En_Sig, TX_Data, Full_Sig, Empty_Sig, Count, Overflow_Sig, Busy_Sig
  );

  modport slave (
    input  Wr_En_Sig, Wr_Data, TX_Done_Sig,
    output TX_En_Sig, TX_Data, Full_Sig, Empty_Sig, Count, Overflow_Sig, Busy_Sig
  );
endinterface

// File: rtl/uart_tx_fifo_module.sv
// Byte FIFO feeding a UART transmit control stage; holds each byte on TX_Data/TX_En_Sig until TX_Done_Sig.
// Latency: write at edge k -> TX_En_Sig/TX_Data valid after edge k+1 (empty FIFO, IDLE); 2 low cycles between frames.
// Ports: CLK, RST (sync, active-high), bus (slave modport). Writes into a full FIFO are dropped and flagged on Overflow_Sig.
module uart_tx_fifo_module #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fifo_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              overflow;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Full is judged on the registered count only, so a pop on the same edge
  // never frees a slot for a write.
  assign wr_acc = bus.Wr_En_Sig && !full;
  assign pop    = (state == IDLE) && !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = SEND;
      SEND:    if (bus.TX_Done_Sig) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem[wr_ptr] <= bus.Wr_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      // Enable follows the state we are entering, so it is high exactly in SEND.
      tx_en    <= (state_nxt == SEND);
      overflow <= bus.Wr_En_Sig && full;
    end
  end

  assign bus.TX_En_Sig    = tx_en;
  assign bus.TX_Data      = tx_data;
  assign bus.Full_Sig     = full;
  assign bus.Empty_Sig    = empty;
  assign bus.Count        = count;
  assign bus.Overflow_Sig = overflow;
  assign bus.Busy_Sig     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_module.sv
module tb_uart_tx_fifo_module;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo_module #(.DEPTH(16), .ADDR_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic       en;
    logic [7:0] data;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for TX_En_Sig to rise; returns number of edges waited.
  task automatic wait_en(input string name, output int waited);
    waited = 0;
    while (!bus.TX_En_Sig && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.TX_En_Sig) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    bus.TX_Done_Sig = 1'b1;
    tick();
    bus.TX_Done_Sig = 1'b0;
  endtask

  function automatic vec_t mk(logic rst, logic wr, logic [7:0] d, logic done, logic en,
                              logic [7:0] data, logic [4:0] cnt, logic full, logic empty,
                              logic ovf, logic busy);
    vec_t v;
    v.rst = rst; v.wr = wr; v.d = d; v.done = done; v.en = en; v.data = data;
    v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf; v.busy = busy;
    return v;
  endfunction

  initial begin
    int w;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.Wr_En_Sig   = 1'b0;
    bus.Wr_Data     = 8'h00;
    bus.TX_Done_Sig = 1'b0;

    //                rst wr  d      done en  data   cnt full empty ovf busy
    vecs[0]  = mk(1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 1, 0, 1);
    vecs[6]  = mk(0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 1, 0, 1);
    vecs[7]  = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 1, 0, 1);
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 1, 0, 0);
    vecs[10] = mk(0, 1, 8'h11, 0, 0, 8'hA5, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 8'h22, 0, 1, 8'h11, 1, 0, 0, 0, 1);
    vecs[12] = mk(0, 1, 8'h33, 0, 1, 8'h11, 2, 0, 0, 0, 1);
    vecs[13] = mk(0, 1, 8'h44, 0, 1, 8'h11, 3, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 8'h00, 1, 0, 8'h11, 3, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 8'h00, 1, 0, 8'h11, 3, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 8'h5A, 0, 1, 8'h22, 3, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 8'h00, 1, 0, 8'h22, 3, 0, 0, 0, 1);
    vecs[18] = mk(0, 0, 8'h00, 0, 0, 8'h22, 3, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 8'h00, 0, 1, 8'h33, 2, 0, 0, 0, 1);
    vecs[20] = mk(0, 0, 8'h00, 1, 0, 8'h33, 2, 0, 0, 0, 1);
    vecs[21] = mk(0, 0, 8'h00, 0, 0, 8'h33, 2, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 8'h00, 0, 1, 8'h44, 1, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 8'h00, 1, 0, 8'h44, 1, 0, 0, 0, 1);
    vecs[24] = mk(0, 0, 8'h00, 0, 0, 8'h44, 1, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 1, 0, 1);
    vecs[26] = mk(0, 0, 8'h00, 1, 0, 8'h5A, 0, 0, 1, 0, 1);
    vecs[27] = mk(0, 0, 8'h00, 0, 0, 8'h5A, 0, 0, 1, 0, 0);

    // Reset with writes pending, single byte, and write colliding with a pop.
    for (int i = 0; i < 28; i++) begin
      RST             = vecs[i].rst;
      bus.Wr_En_Sig   = vecs[i].wr;
      bus.Wr_Data     = vecs[i].d;
      bus.TX_Done_Sig = vecs[i].done;
      tick();
      check($sformatf("v%0d_en", i),    32'(bus.TX_En_Sig),    32'(vecs[i].en));
      check($sformatf("v%0d_data", i),  32'(bus.TX_Data),      32'(vecs[i].data));
      check($sformatf("v%0d_cnt", i),   32'(bus.Count),        32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i),  32'(bus.Full_Sig),     32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(bus.Empty_Sig),    32'(vecs[i].empty));
      check($sformatf("v%0d_ovf", i),   32'(bus.Overflow_Sig), 32'(vecs[i].ovf));
      check($sformatf("v%0d_busy", i),  32'(bus.Busy_Sig),     32'(vecs[i].busy));
    end
    bus.Wr_En_Sig   = 1'b0;
    bus.TX_Done_Sig = 1'b0;

    // Long frame: byte held 20 cycles, then done -> enable drops, busy clears.
    bus.Wr_En_Sig = 1'b1;
    bus.Wr_Data   = 8'h3C;
    tick();
    bus.Wr_En_Sig = 1'b0;
    tick();
    check("long_en_rise", 32'(bus.TX_En_Sig), 32'd1);
    repeat (19) tick();
    check("long_en_hold", 32'(bus.TX_En_Sig), 32'd1);
    check("long_data_hold", 32'(bus.TX_Data), 32'h3C);
    pulse_done();
    check("long_en_fall", 32'(bus.TX_En_Sig), 32'd0);
    check("long_busy_gap", 32'(bus.Busy_Sig), 32'd1);
    tick();
    tick();
    check("long_busy_clr", 32'(bus.Busy_Sig), 32'd0);
    check("long_data_kept", 32'(bus.TX_Data), 32'h3C);

    // Ordering and pointer wrap: 20 bytes, each frame completed after 5 cycles.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bus.Wr_En_Sig = 1'b1;
          bus.Wr_Data   = 8'(i);
          tick();
          bus.Wr_En_Sig = 1'b0;
          tick();
          tick();
        end
      end
      begin
        int low;
        for (int f = 0; f < 20; f++) begin
          wait_en("wrap_en", low);
          if (f > 0) check($sformatf("wrap_gap%0d", f), 32'(low), 32'd2);
          check($sformatf("wrap_byte%0d", f), 32'(bus.TX_Data), 32'(f));
          repeat (4) tick();
          pulse_done();
          check($sformatf("wrap_fall%0d", f), 32'(bus.TX_En_Sig), 32'd0);
        end
      end
    join
    tick();
    tick();
    check("wrap_empty", 32'(bus.Empty_Sig), 32'd1);

    // Full and overflow: 19 consecutive writes with no completion.
    for (int i = 0; i < 19; i++) begin
      bus.Wr_En_Sig = 1'b1;
      bus.Wr_Data   = 8'(8'hB0 + i);
      tick();
      if (i == 16) begin
        check("full_cnt", 32'(bus.Count), 32'd16);
        check("full_flag", 32'(bus.Full_Sig), 32'd1);
        check("full_no_ovf", 32'(bus.Overflow_Sig), 32'd0);
      end
      if (i >= 17) check($sformatf("ovf_pulse%0d", i), 32'(bus.Overflow_Sig), 32'd1);
    end
    bus.Wr_En_Sig = 1'b0;
    tick();
    check("ovf_clear", 32'(bus.Overflow_Sig), 32'd0);
    check("ovf_cnt_kept", 32'(bus.Count), 32'd16);
    check("ovf_first_byte", 32'(bus.TX_Data), 32'hB0);
    pulse_done();
    for (int f = 0; f < 16; f++) begin
      wait_en("drain_en", w);
      check($sformatf("drain_byte%0d", f), 32'(bus.TX_Data), 32'(8'hB1 + f));
      pulse_done();
    end
    repeat (4) tick();
    check("drain_no_extra", 32'(bus.TX_En_Sig), 32'd0);
    check("drain_last", 32'(bus.TX_Data), 32'hC0);
    check("drain_empty", 32'(bus.Empty_Sig), 32'd1);

    // Reset in the middle of a frame with 5 bytes queued.
    for (int i = 0; i < 6; i++) begin
      bus.Wr_En_Sig = 1'b1;
      bus.Wr_Data   = 8'(8'hD0 + i);
      tick();
    end
    bus.Wr_En_Sig = 1'b0;
    check("mid_pre_cnt", 32'(bus.Count), 32'd5);
    check("mid_pre_en", 32'(bus.TX_En_Sig), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_en", 32'(bus.TX_En_Sig), 32'd0);
    check("mid_cnt", 32'(bus.Count), 32'd0);
    check("mid_empty", 32'(bus.Empty_Sig), 32'd1);
    check("mid_busy", 32'(bus.Busy_Sig), 32'd0);
    check("mid_data", 32'(bus.TX_Data), 32'h00);
    repeat (3) begin
      pulse_done();
      tick();
    end
    check("mid_after_en", 32'(bus.TX_En_Sig), 32'd0);
    check("mid_after_busy", 32'(bus.Busy_Sig), 32'd0);
    check("mid_after_data", 32'(bus.TX_Data), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_module.md
# uart_tx_fifo_module

Byte buffer and sequencer that sits directly upstream of the UART transmit control stage. It accepts bytes from the host logic through a single-cycle write strobe and stores them in a DEPTH-entry FIFO. It then presents them one at a time on TX_En_Sig/TX_Data, holding each byte until the transmitter returns TX_Done_Sig. Host logic can therefore queue bursts of bytes without tracking frame timing.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH); pointer width.
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- Wr_En_Sig  input  1  write strobe; one byte is accepted per cycle while high.
- Wr_Data  input  8  byte to queue; sampled when Wr_En_Sig=1.
- TX_Done_Sig  input  1  one-cycle completion pulse from the transmit control stage.
- TX_En_Sig  output  1  transmit enable to the transmit control stage.
- TX_Data  output  8  byte under transmission; stable while TX_En_Sig=1.
- Full_Sig  output  1  set when Count==DEPTH.
- Empty_Sig  output  1  set when Count==0.
- Count  output  ADDR_W+1  number of bytes stored; excludes the byte currently in TX_Data.
- Overflow_Sig  output  1  one-cycle pulse when a write is dropped.
- Busy_Sig  output  1  set when the state is not IDLE.

## Operation
- Storage: 8-bit memory of DEPTH entries with wr_ptr and rd_ptr, each ADDR_W bits, wrapping modulo DEPTH. Count is a registered counter; Full_Sig and Empty_Sig are decoded from it.
- Write rule: a write is accepted iff Wr_En_Sig=1 and Full_Sig=0, both sampled at the same edge. On acceptance: mem[wr_ptr]<=Wr_Data and wr_ptr+1.
  - A write while Full_Sig=1 is dropped: no state change, Overflow_Sig=1 for the following cycle.
  - A pop in the same cycle does not make room for a write when Full_Sig=1.
- Count update: +1 on an accepted write only; -1 on a pop only; unchanged on simultaneous write and pop.
- State machine with three states:
  - IDLE: if Count!=0, pop: TX_Data<=mem[rd_ptr], rd_ptr+1, TX_En_Sig<=1, go to SEND. Otherwise stay.
  - SEND: hold TX_En_Sig=1 and TX_Data unchanged. When TX_Done_Sig=1, set TX_En_Sig<=0 and go to GAP.
  - GAP: stay exactly one cycle, then go to IDLE. This guarantees TX_En_Sig is low between frames so the transmitter returns to its start state.
- TX_Done_Sig is ignored in IDLE and GAP.
- TX_Data keeps the last transmitted byte after TX_En_Sig falls. It changes only on a pop.
- Reset (RST=1 at an edge), applied in any state and including mid-frame:
  - state=IDLE, pointers=0, Count=0.
  - TX_En_Sig=0, TX_Data=8'h00, Empty_Sig=1, Full_Sig=0, Overflow_Sig=0, Busy_Sig=0.
  - All queued bytes are discarded. RST has priority over writes in the same cycle.

## Timing
- Write-to-enable latency with an empty FIFO and IDLE state: write sampled at edge k; Count=1 after k; pop at edge k+1; TX_En_Sig=1 and TX_Data valid after edge k+1.
- Empty_Sig falls after edge k and rises again after edge k+1 if no further write arrives.
- Back-to-back frames: TX_Done_Sig sampled at edge d; TX_En_Sig=0 after d; GAP occupies edge d+1; the next pop happens at edge d+2. TX_En_Sig is low for exactly 2 cycles between frames.
- Overflow_Sig is registered and high for exactly one cycle per dropped write. Consecutive dropped writes hold it high continuously.
- Busy_Sig is registered from state, so it is high during SEND and GAP.
- No combinational path from any input to any output.

## Test plan
- Reset values: assert RST for 2 cycles with Wr_En_Sig=1 and Wr_Data=8'hFF -> all outputs at their reset values and Count=0; after release no byte appears on TX_Data.
- Single byte: write 8'hA5 at edge k -> TX_En_Sig=1 with TX_Data=8'hA5 after edge k+1. Pulse TX_Done_Sig 20 cycles later -> TX_En_Sig=0 on the next cycle; Busy_Sig=0 two cycles after that.
- Ordering and wrap: write 8'h00..8'h13 (20 bytes, DEPTH=16) while completing each frame with TX_Done_Sig after 5 cycles -> all 20 bytes transmitted in order; TX_En_Sig low exactly 2 cycles between frames; pointers wrap without loss.
- Full and overflow: hold TX_Done_Sig=0 and write 18 bytes on consecutive cycles -> the first byte goes to TX_Data and 16 are stored (Count=16, Full_Sig=1). The 18th write is dropped with a one-cycle Overflow_Sig pulse and does not appear in the output sequence.
- Simultaneous write and pop: with Count=3 in IDLE after GAP, write 8'h5A on the pop edge -> Count stays 3 and 8'h5A is transmitted fourth.
- Reset mid-frame: assert RST while in SEND with Count=5 -> TX_En_Sig=0, Count=0 and Empty_Sig=1 after the edge. Later TX_Done_Sig pulses cause no activity.
